// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Single-bit full subtractor: d = a - b - bin, bout set on borrow.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: captures a, b, bin, then resolves one bit per cycle
// LSB first and presents diff/bout with a valid/ready handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             cell_d;
    logic             cell_bout;

    fs_cell u_fs_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next-state, datapath and handshake decode; diff/bout only update on the final bit
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        diff_d      = diff_q;
        br_d        = br_q;
        bout_d      = bout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_RUN;
                    cnt_d      = {CNT_W{1'b0}};
                    a_d        = a;
                    b_d        = b;
                    br_d       = bin;
                    in_ready_d = 1'b0;
                end else begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = cell_bout;
                res_d = {cell_d, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d     = ST_DONE;
                    diff_d      = {cell_d, res_q[WIDTH-1:1]};
                    bout_d      = cell_bout;
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // All state registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            diff_q      <= {WIDTH{1'b0}};
            br_q        <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            diff_q      <= diff_d;
            br_q        <= br_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corners plus random
// back-to-back operations against an arithmetic reference.
module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;

    int n_vec;
    int n_err;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation; returns at a negedge with the block back in IDLE.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input int hold, input bit scramble);
        logic [W:0]   exp_v;
        logic [W-1:0] exp_d;
        logic         exp_b;
        int           w;
        int           lat;
        exp_v = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
        exp_d = exp_v[W-1:0];
        exp_b = exp_v[W];

        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);

        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(negedge clk);
        lat = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            if (scramble) begin
                a         = W'($urandom);
                b         = W'($urandom);
                bin       = 1'($urandom);
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(lat), 64'(W + 1));
        chk("diff", 64'(diff), 64'(exp_d));
        chk("bout", 64'(bout), 64'(exp_b));
        chk("in_ready_in_done", 64'(in_ready), 64'd0);

        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            if (scramble) begin
                a        = W'($urandom);
                b        = W'($urandom);
                bin      = 1'($urandom);
            end
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_diff", 64'(diff), 64'(exp_d));
            chk("hold_bout", 64'(bout), 64'(exp_b));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);

        // Directed corners
        do_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b0, 0, 1'b0);
        do_op(16'hA5A5, 16'h5A5A, 1'b0, 10, 1'b0);

        // Reset in the middle of RUN abandons the operation
        a = 16'h4321; b = 16'h1111; bin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_diff", 64'(diff), 64'd0);
        chk("midrst_bout", 64'(bout), 64'd0);
        repeat (20) begin
            @(negedge clk);
            chk("midrst_no_result", 64'(out_valid), 64'd0);
        end
        do_op(16'h4321, 16'h1111, 1'b1, 0, 1'b0);

        // Random back-to-back traffic with scrambled inputs and random stall
        for (int k = 0; k < 1000; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
